// File: rtl/uart_rx_frame.sv
// -----------------------------------------------------------------------------
// uart_rx_frame
//
// 8N1 serial receiver feeding the control-panel command decoder. The decoder
// triggers on the falling edge of rx_busy and reads rx_byte at that moment.
// Bad frames are therefore delivered as 8'h00 (the decoder's no-op class).
//
// Optional feature macro: UART_RX_MAJORITY_EN
//   defined   : every sample (start, data, stop) is the 2-of-3 majority of
//               rxd_s at centre-1, centre and centre+1. The decision lands one
//               clock later, so all output timing moves by +1 clock.
//   undefined : a single sample of rxd_s at the bit centre.
//
// Parameters
//   clk_speed  clock frequency in Hz
//   baud       line rate; D = clk_speed/baud clocks per bit (D >= 4), H = D/2
//
// Ports
//   clk         in   system clock, all logic on posedge
//   r_          in   asynchronous active-low reset
//   rxd         in   raw serial line, idle high, asynchronous to clk
//   rx_byte     out  last received byte (LSB first on the line); stable while
//                    rx_busy is low
//   rx_busy     out  high from start-bit detect until the frame is finished
//   rx_valid    out  one-clock pulse: good frame, rx_byte updated
//   rx_ferr     out  one-clock pulse: stop bit sampled low, rx_byte <= 8'h00
//   rx_state_o  out  debug view of the receive state machine
//
// Handshake: there is no back-pressure. rx_valid / rx_ferr are single-clock
// strobes qualified by nothing else; rx_byte and the rx_busy fall are
// committed on the same edge, so a consumer that samples rx_byte on the
// busy fall always sees the new data.
// -----------------------------------------------------------------------------
module uart_rx_frame #(
  parameter int clk_speed = 50_000_000,
  parameter int baud      = 9600
) (
  input  logic       clk,
  input  logic       r_,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       rx_busy,
  output logic       rx_valid,
  output logic       rx_ferr,
  output logic [2:0] rx_state_o
);

  localparam int D  = clk_speed / baud;
  localparam int H  = D / 2;
  localparam int CW = (D > 1) ? $clog2(D) : 1;

  localparam logic [CW-1:0] CNT_FULL = CW'(D - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  // ---------------------------------------------------------------------------
  // Input synchronizer. Resets to 1 so a reset never looks like a start bit.
  // ---------------------------------------------------------------------------
  logic sync1_q;
  logic rxd_s_q;

  always_ff @(posedge clk or negedge r_) begin
    if (!r_) begin
      sync1_q <= 1'b1;
      rxd_s_q <= 1'b1;
    end else begin
      sync1_q <= rxd;
      rxd_s_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    byte_q, byte_d;
  logic          busy_q, busy_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  // tick marks the bit-centre clock while a frame is being sampled.
  logic tick;
  // act: this edge consumes a sample; samp: the sampled line value.
  logic act;
  logic samp;

  assign tick = ((state_q == S_START) || (state_q == S_DATA) ||
                 (state_q == S_STOP)) && (cnt_q == '0);

`ifdef UART_RX_MAJORITY_EN
  // hist_q[0] holds rxd_s from the previous clock, hist_q[1] the one before.
  // One clock after the centre tick those are the centre and centre-1
  // values, and rxd_s_q itself is centre+1.
  logic [1:0] hist_q;
  logic       pend_q;

  always_ff @(posedge clk or negedge r_) begin
    if (!r_) begin
      hist_q <= 2'b11;
      pend_q <= 1'b0;
    end else begin
      hist_q <= {hist_q[0], rxd_s_q};
      pend_q <= tick;
    end
  end

  assign act  = pend_q;
  assign samp = (rxd_s_q & hist_q[0]) | (rxd_s_q & hist_q[1]) |
                (hist_q[0] & hist_q[1]);
`else
  assign act  = tick;
  assign samp = rxd_s_q;
`endif

  // ---------------------------------------------------------------------------
  // Bit-period counter. Loaded with H-1 on start detect so the first tick
  // falls mid start bit, then free-runs D-1..0 giving one tick per bit.
  // In BREAK it measures a full bit time of continuous high line.
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (!rxd_s_q) cnt_d = CNT_HALF;
      end
      S_START, S_DATA, S_STOP: begin
        if (cnt_q == '0) cnt_d = CNT_FULL;
        else             cnt_d = cnt_q - CNT_ONE;
      end
      S_BREAK: begin
        if (!rxd_s_q)          cnt_d = CNT_FULL;
        else if (cnt_q != '0)  cnt_d = cnt_q - CNT_ONE;
      end
      default: cnt_d = '0;
    endcase
    // Entering BREAK always starts a fresh full-bit high measurement,
    // regardless of where the majority-delayed decision left the counter.
    if ((state_q == S_STOP) && act && !samp) cnt_d = CNT_FULL;
  end

  // ---------------------------------------------------------------------------
  // Receive state machine
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    byte_d    = byte_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rxd_s_q) begin
          state_d   = S_START;
          busy_d    = 1'b1;
          bit_idx_d = 3'd0;
        end
      end

      S_START: begin
        if (act) begin
          if (samp) begin
            // Line was high again mid start bit: glitch, drop it silently.
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (act) begin
          shreg_d   = {samp, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end
      end

      S_STOP: begin
        if (act) begin
          if (samp) begin
            byte_d  = shreg_q;
            valid_d = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            // Framing error: hand the decoder a no-op and keep busy high
            // until the line has been idle for a full bit.
            byte_d  = 8'h00;
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end

      S_BREAK: begin
        if (rxd_s_q && (cnt_q == '0)) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge r_) begin
    if (!r_) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shreg_q   <= 8'h00;
      byte_q    <= 8'h00;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      byte_q    <= byte_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  assign rx_byte    = byte_q;
  assign rx_busy    = busy_q;
  assign rx_valid   = valid_q;
  assign rx_ferr    = ferr_q;
  assign rx_state_o = state_q;

endmodule
